// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with IF/ID register, req/ack fetch port, branch redirect and stall hold buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMemReqF,
    output logic [31:0] IMemAddrF,
    input  logic [31:0] IMemRData,
    input  logic        IMemAck,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] PCF
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pcp4_q, buf_pcp4_d;
    logic [31:0] redir_q, redir_d;
    logic        redirect, fire;
    logic [31:0] pc_plus4, target;

    assign IMemReqF  = (state_q == S_REQ) || (state_q == S_DROP);
    assign IMemAddrF = pc_q;
    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;
    assign redirect  = PCSrcD && valid_q && !StallD;
    assign fire      = IMemReqF && IMemAck;
    assign pc_plus4  = pc_q + 32'd4;
    assign target    = PCBranchD & ~32'd3;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // datapath registers: PC, IF/ID, hold buffer, pending redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
            buf_instr_q <= '0;
            buf_pcp4_q  <= '0;
            redir_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pcp4_q  <= buf_pcp4_d;
            redir_q     <= redir_d;
        end
    end

    // next-state: a stalled delivery parks in HOLD, an unacked redirect drains in DROP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = (!fire && redirect) ? S_DROP :
                              (fire && !redirect && StallD) ? S_HOLD : S_REQ;
            S_DROP: state_d = fire ? S_REQ : S_DROP;
            S_HOLD: state_d = StallD ? S_HOLD : S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath next values; IF/ID takes a bubble whenever Decode advances without a delivery
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = StallD ? valid_q : 1'b0;
        buf_instr_d = buf_instr_q;
        buf_pcp4_d  = buf_pcp4_q;
        redir_d     = redir_q;
        case (state_q)
            S_REQ: begin
                if (fire && !redirect) begin
                    pc_d = pc_plus4;
                    if (StallD) begin
                        buf_instr_d = IMemRData;
                        buf_pcp4_d  = pc_plus4;
                    end else begin
                        instr_d = IMemRData;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                    end
                end else if (fire) begin
                    pc_d = target;
                end else if (redirect) begin
                    redir_d = target;
                end
            end
            S_DROP: pc_d = fire ? redir_q : pc_q;
            S_HOLD: begin
                if (redirect) begin
                    pc_d = target;
                end else if (!StallD) begin
                    instr_d = buf_instr_q;
                    pcp4_d  = buf_pcp4_q;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset/wrap sequences and randomized fetch-order checking
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        IMemReqF;
    logic [31:0] IMemAddrF;
    logic [31:0] IMemRData;
    logic        IMemAck;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] PCF;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] RPC = 32'h0040_0000;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .IMemReqF(IMemReqF), .IMemAddrF(IMemAddrF),
        .IMemRData(IMemRData), .IMemAck(IMemAck), .StallD(StallD), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .PCF(PCF)
    );

    always #5 clk = ~clk;

    // instruction memory contents as a function of address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // memory model answers combinationally with the word at the requested address
    assign IMemRData = mem(IMemAddrF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ack, stall, pcsrc;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pcp4;
    } vec_t;

    function automatic vec_t mk(input logic ack, stall, pcsrc, input logic [31:0] tgt,
                                input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, pcp4);
        vec_t v;
        v.ack = ack; v.stall = stall; v.pcsrc = pcsrc; v.tgt = tgt;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pcp4 = pcp4;
        return v;
    endfunction

    vec_t vecs[15];

    logic        p_stall, p_redir, p_pend;
    logic [31:0] p_addr, p_tgt, p_instr, p_pcp4;
    logic        p_valid;
    logic [31:0] exp_pc;
    int          ndel;

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 1, 32'h0040_0004, 1, mem(32'h0040_0000), 32'h0040_0004);
        vecs[3]  = mk(1, 1, 0, 0, 1, 32'h0040_0008, 1, mem(32'h0040_0004), 32'h0040_0008);
        vecs[4]  = mk(1, 1, 0, 0, 0, 32'h0040_000C, 1, mem(32'h0040_0004), 32'h0040_0008);
        vecs[5]  = mk(1, 1, 0, 0, 0, 32'h0040_000C, 1, mem(32'h0040_0004), 32'h0040_0008);
        vecs[6]  = mk(1, 0, 0, 0, 0, 32'h0040_000C, 1, mem(32'h0040_0004), 32'h0040_0008);
        vecs[7]  = mk(1, 0, 0, 0, 1, 32'h0040_000C, 1, mem(32'h0040_0008), 32'h0040_000C);
        vecs[8]  = mk(0, 0, 1, 32'h0040_0100, 1, 32'h0040_0010, 1, mem(32'h0040_000C), 32'h0040_0010);
        vecs[9]  = mk(0, 0, 0, 0, 1, 32'h0040_0010, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 1, 32'h0040_0010, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 1, 32'h0040_0100, 0, 0, 0);
        vecs[12] = mk(1, 0, 1, 32'h0040_0203, 1, 32'h0040_0104, 1, mem(32'h0040_0100), 32'h0040_0104);
        vecs[13] = mk(1, 0, 0, 0, 1, 32'h0040_0200, 0, 0, 0);
        vecs[14] = mk(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h0040_0204, 1, mem(32'h0040_0200), 32'h0040_0204);

        reset = 1'b1; IMemAck = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
        #3;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'b0, IMemReqF}, {31'b0, vecs[i].req});
            chk($sformatf("v%0d_addr", i), IMemAddrF, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'b0, ValidD}, {31'b0, vecs[i].valid});
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_instr", i), InstrD, vecs[i].instr);
                chk($sformatf("v%0d_pcp4", i), PCPlus4D, vecs[i].pcp4);
            end
            IMemAck = vecs[i].ack; StallD = vecs[i].stall;
            PCSrcD = vecs[i].pcsrc; PCBranchD = vecs[i].tgt;
        end

        // wrap of PC+4 past 0xFFFF_FFFC
        @(negedge clk);
        chk("wrap_addr", IMemAddrF, 32'hFFFF_FFFC);
        chk("wrap_bubble", {31'b0, ValidD}, 32'd0);
        IMemAck = 1'b1; StallD = 1'b0; PCSrcD = 1'b0;
        @(negedge clk);
        chk("wrap_pcf", PCF, 32'h0);
        chk("wrap_valid", {31'b0, ValidD}, 32'd1);
        chk("wrap_pcp4", PCPlus4D, 32'h0);
        chk("wrap_instr", InstrD, mem(32'hFFFF_FFFC));
        StallD = 1'b1;

        // asynchronous reset while parked in the hold state
        @(negedge clk);
        chk("hold_req", {31'b0, IMemReqF}, 32'd0);
        chk("hold_pcf", PCF, 32'h4);
        #1 reset = 1'b1;
        #1;
        chk("arst_req", {31'b0, IMemReqF}, 32'd0);
        chk("arst_pcf", PCF, RPC);
        chk("arst_valid", {31'b0, ValidD}, 32'd0);
        chk("arst_instr", InstrD, 32'h0);
        chk("arst_pcp4", PCPlus4D, 32'h0);

        // randomized traffic: delivered stream must follow program order with redirects
        @(negedge clk);
        reset = 1'b0; StallD = 1'b0; IMemAck = 1'b0; PCSrcD = 1'b0;
        exp_pc = RPC; ndel = 0;
        p_stall = 1'b0; p_redir = 1'b0; p_pend = 1'b0;
        p_addr = '0; p_tgt = '0; p_instr = InstrD; p_pcp4 = PCPlus4D; p_valid = ValidD;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (p_pend) begin
                chk("req_held", {31'b0, IMemReqF}, 32'd1);
                chk("addr_held", IMemAddrF, p_addr);
            end
            if (p_redir) begin
                chk("redir_bubble", {31'b0, ValidD}, 32'd0);
                exp_pc = p_tgt & ~32'd3;
            end else if (p_stall) begin
                chk("stall_valid", {31'b0, ValidD}, {31'b0, p_valid});
                chk("stall_instr", InstrD, p_instr);
                chk("stall_pcp4", PCPlus4D, p_pcp4);
            end else if (ValidD) begin
                chk("seq_pcp4", PCPlus4D, exp_pc + 32'd4);
                chk("seq_instr", InstrD, mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                ndel++;
            end
            IMemAck   = ($urandom_range(0, 9) < 5);
            StallD    = ($urandom_range(0, 9) < 2);
            PCSrcD    = ($urandom_range(0, 9) < 2);
            PCBranchD = {16'h0040, 16'($urandom)};
            p_stall = StallD;
            p_redir = PCSrcD && ValidD && !StallD;
            p_pend  = IMemReqF && !IMemAck;
            p_addr  = IMemAddrF;
            p_tgt   = PCBranchD;
            p_instr = InstrD; p_pcp4 = PCPlus4D; p_valid = ValidD;
        end
        chk("progress", {31'b0, ndel > 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
